// File: rtl/soc_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// soc_bus_ctrl_if
//   OBI request/response bundle between the SoC arbiter output and the bus
//   controller.
//   master modport (arbiter side):   drives req, addr, we; sees gnt, rvalid,
//                                     rdata, err
//   slave modport  (controller side): sees req, addr, we; drives gnt, rvalid,
//                                     rdata, err
//   req    : request, held with addr/we stable until gnt
//   addr   : 32-bit byte address, bits [31:24] select the slave
//   we     : write enable
//   gnt    : grant, accepts the current request
//   rvalid : response valid
//   rdata  : read data, zero whenever rvalid is low
//   err    : error flag, qualified by rvalid
// -----------------------------------------------------------------------------
interface soc_bus_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/soc_bus_ctrl.sv
// -----------------------------------------------------------------------------
// soc_bus_ctrl
//   Single-outstanding OBI bus controller sitting between the arbitrated SoC
//   request port and every SoC slave. addr[31:24] selects a local slave
//   (DRAM, IRAM, UART: one-cycle strobe, data the cycle after) or an external
//   slave (I2C, pinmux: reached through the OBI-WB bridge). Unmapped
//   addresses and external accesses that stall too long complete with an
//   error response so the core never hangs.
//
//   Ports
//     clk_i, rst_ni        clock, asynchronous active-low reset
//     obi                  OBI request/response bundle (slave modport)
//     dram_en_o            DRAM access strobe (one cycle)
//     iram_en_o            IRAM access strobe (one cycle)
//     uart_en_o            UART access strobe (one cycle)
//     dram_rdata_i         DRAM read data, valid the cycle after the strobe
//     iram_rdata_i         IRAM read data, valid the cycle after the strobe
//     uart_rdata_i         UART read data, valid the cycle after the strobe
//     ext_req_o            request to the OBI-WB bridge
//     ext_gnt_i            bridge grant
//     ext_rvalid_i         bridge response valid
//     ext_rdata_i          bridge read data
//     timeout_cnt_o        saturating count of external timeouts
// -----------------------------------------------------------------------------
module soc_bus_ctrl #(
  parameter logic [7:0]  DRAM_MASK      = 8'h00,
  parameter logic [7:0]  IRAM_MASK      = 8'h02,
  parameter logic [7:0]  UART_MASK      = 8'h0A,
  parameter logic [7:0]  I2C_MASK       = 8'h0E,
  parameter logic [7:0]  PINMUX_MASK    = 8'h0F,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  soc_bus_ctrl_if.slave        obi,
  output logic                 dram_en_o,
  output logic                 iram_en_o,
  output logic                 uart_en_o,
  input  logic [31:0]          dram_rdata_i,
  input  logic [31:0]          iram_rdata_i,
  input  logic [31:0]          uart_rdata_i,
  output logic                 ext_req_o,
  input  logic                 ext_gnt_i,
  input  logic                 ext_rvalid_i,
  input  logic [31:0]          ext_rdata_i,
  output logic [7:0]           timeout_cnt_o
);

  // The wait counter only ever holds 0 .. TIMEOUT_CYCLES-1: reaching the
  // last value either sees the awaited event or leaves for ERR_RESP.
  localparam int unsigned    WAIT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOC_RESP = 3'd1,
    EXT_GNT  = 3'd2,
    EXT_RESP = 3'd3,
    ERR_RESP = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SEL_DRAM = 2'd0,
    SEL_IRAM = 2'd1,
    SEL_UART = 2'd2
  } sel_e;

  state_e            state_q, state_d;
  sel_e              sel_q,   sel_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;
  logic [7:0]        tmo_q,   tmo_d;
  logic              tmo_hit;

  logic [7:0] top;
  logic       hit_dram, hit_iram, hit_uart, hit_ext, hit_loc;
  logic       wait_last;

  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  // Only the slave-select byte is decoded; the rest of the address and the
  // write enable travel to the slaves on their own buses.
  logic unused_bus;
  assign unused_bus = ^{obi.we, obi.addr[23:0]};

  // Address decode
  always_comb begin
    top      = obi.addr[31:24];
    hit_dram = (top == DRAM_MASK);
    hit_iram = (top == IRAM_MASK);
    hit_uart = (top == UART_MASK);
    hit_ext  = (top == I2C_MASK) || (top == PINMUX_MASK);
    hit_loc  = hit_dram || hit_iram || hit_uart;
  end

  assign wait_last = (wait_q == WAIT_LAST);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= SEL_DRAM;
      wait_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wait_d  = wait_q;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (obi.req) begin
          if (hit_loc) begin
            state_d = LOC_RESP;
            if (hit_dram)      sel_d = SEL_DRAM;
            else if (hit_iram) sel_d = SEL_IRAM;
            else               sel_d = SEL_UART;
          end else if (hit_ext) begin
            state_d = EXT_GNT;
            wait_d  = '0;
          end else begin
            state_d = ERR_RESP;
          end
        end
      end
      LOC_RESP: state_d = IDLE;
      EXT_GNT: begin
        // A grant arriving on the last wait cycle still wins.
        if (ext_gnt_i) begin
          state_d = EXT_RESP;
          wait_d  = '0;
        end else if (wait_last) begin
          state_d = ERR_RESP;
          tmo_hit = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      EXT_RESP: begin
        if (ext_rvalid_i) begin
          state_d = IDLE;
        end else if (wait_last) begin
          state_d = ERR_RESP;
          tmo_hit = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ERR_RESP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    tmo_d = (tmo_hit && (tmo_q != 8'hFF)) ? tmo_q + 8'd1 : tmo_q;
  end

  // Output logic. Everything is gated by rst_ni so the bus goes quiet the
  // moment reset is asserted, even while the requester still holds req.
  always_comb begin
    gnt       = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    err       = 1'b0;
    dram_en_o = 1'b0;
    iram_en_o = 1'b0;
    uart_en_o = 1'b0;
    ext_req_o = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          // External hits are not granted here; the grant comes from the
          // bridge in EXT_GNT.
          if (obi.req && !hit_ext) gnt = 1'b1;
          dram_en_o = obi.req && hit_dram;
          iram_en_o = obi.req && hit_iram;
          uart_en_o = obi.req && hit_uart;
        end
        LOC_RESP: begin
          rvalid = 1'b1;
          case (sel_q)
            SEL_DRAM: rdata = dram_rdata_i;
            SEL_IRAM: rdata = iram_rdata_i;
            SEL_UART: rdata = uart_rdata_i;
            default:  rdata = '0;
          endcase
        end
        EXT_GNT: begin
          if (ext_gnt_i) begin
            gnt       = 1'b1;
            ext_req_o = 1'b1;
          end else if (wait_last) begin
            // Timeout: accept the request ourselves and withdraw it from
            // the bridge so it cannot be granted behind our back.
            gnt = 1'b1;
          end else begin
            ext_req_o = 1'b1;
          end
        end
        EXT_RESP: begin
          rvalid = ext_rvalid_i;
          rdata  = ext_rvalid_i ? ext_rdata_i : 32'h0;
        end
        ERR_RESP: begin
          rvalid = 1'b1;
          err    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign obi.gnt       = gnt;
  assign obi.rvalid    = rvalid;
  assign obi.rdata     = rdata;
  assign obi.err       = err;
  assign timeout_cnt_o = tmo_q;

endmodule

// File: tb/tb_soc_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_soc_bus_ctrl
//   Transaction-level bench for soc_bus_ctrl. Each transaction is described
//   by its target class, bridge grant/response delays and data; the expected
//   cycle-by-cycle bus behaviour is derived from those delays and the
//   timeout limit. Inputs change on the falling edge, outputs are sampled 1
//   time unit later.
// -----------------------------------------------------------------------------
module tb_soc_bus_ctrl;
  localparam int T = 16;

  // kinds: 0 dram, 1 iram, 2 uart, 3 i2c, 4 pinmux, 5 unmapped
  typedef struct {
    logic [31:0] addr;
    logic        we;
    int          kind;
    int          gd;    // ext_req cycle index carrying ext_gnt_i
    int          rd;    // response-wait cycle index carrying ext_rvalid_i
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        dram_en, iram_en, uart_en;
  logic [31:0] dram_rd, iram_rd, uart_rd;
  logic        ext_req, ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic [7:0]  tcnt;

  int n_chk  = 0;
  int n_fail = 0;
  int tmo_m  = 0;

  always #5 clk = ~clk;

  soc_bus_ctrl_if bus ();

  soc_bus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .obi           (bus),
    .dram_en_o     (dram_en),
    .iram_en_o     (iram_en),
    .uart_en_o     (uart_en),
    .dram_rdata_i  (dram_rd),
    .iram_rdata_i  (iram_rd),
    .uart_rdata_i  (uart_rd),
    .ext_req_o     (ext_req),
    .ext_gnt_i     (ext_gnt),
    .ext_rvalid_i  (ext_rvalid),
    .ext_rdata_i   (ext_rdata),
    .timeout_cnt_o (tcnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_o(input string tag, input bit g, input bit rv,
                          input logic [31:0] rd, input bit er, input bit de,
                          input bit ie, input bit ue, input bit xr);
    #1;
    chk({tag, ".gnt"},    32'(bus.gnt),    32'(g));
    chk({tag, ".rvalid"}, 32'(bus.rvalid), 32'(rv));
    chk({tag, ".rdata"},  bus.rdata,       rd);
    chk({tag, ".err"},    32'(bus.err),    32'(er));
    chk({tag, ".dram_en"}, 32'(dram_en),   32'(de));
    chk({tag, ".iram_en"}, 32'(iram_en),   32'(ie));
    chk({tag, ".uart_en"}, 32'(uart_en),   32'(ue));
    chk({tag, ".ext_req"}, 32'(ext_req),   32'(xr));
    chk({tag, ".tcnt"},   32'(tcnt),       32'(tmo_m));
  endtask

  // Random slave data plus random stray bridge handshakes.
  task automatic rnd_bg();
    dram_rd    = $urandom;
    iram_rd    = $urandom;
    uart_rd    = $urandom;
    ext_rdata  = $urandom;
    ext_gnt    = 1'($urandom_range(0, 1));
    ext_rvalid = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [7:0] top_of(input int k);
    case (k)
      0:       return 8'h00;
      1:       return 8'h02;
      2:       return 8'h0A;
      3:       return 8'h0E;
      default: return 8'h0F;
    endcase
  endfunction

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)  return r;
    if (r == 6) return T - 1;
    if (r == 7) return T;
    return T + r;
  endfunction

  function automatic txn_t gen();
    txn_t t;
    logic [7:0] top;
    t.kind = $urandom_range(0, 5);
    if (t.kind == 5) begin
      do top = 8'($urandom);
      while (top inside {8'h00, 8'h02, 8'h0A, 8'h0E, 8'h0F});
    end else begin
      top = top_of(t.kind);
    end
    t.addr = {top, 24'($urandom)};
    t.we   = 1'($urandom_range(0, 1));
    t.gd   = pick_delay();
    t.rd   = pick_delay();
    t.data = $urandom;
    return t;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Final response cycle; optionally presents the next request, which must
  // not be granted while this response is still on the bus.
  task automatic drive_req(input bit on, input txn_t n);
    bus.req  = on;
    bus.addr = on ? n.addr : 32'h0;
    bus.we   = on ? n.we : 1'b0;
  endtask

  task automatic run(input txn_t t, input txn_t n, input bit ovl);
    bit granted;
    bit de, ie, ue;
    de = (t.kind == 0);
    ie = (t.kind == 1);
    ue = (t.kind == 2);
    @(negedge clk);
    rnd_bg();
    bus.req = 1'b1; bus.addr = t.addr; bus.we = t.we;
    if (t.kind <= 2) begin
      expect_o("loc.c0", 1, 0, 32'h0, 0, de, ie, ue, 0);
      @(negedge clk);
      rnd_bg();
      if (de) dram_rd = t.data;
      if (ie) iram_rd = t.data;
      if (ue) uart_rd = t.data;
      drive_req(ovl, n);
      expect_o("loc.resp", 0, 1, t.data, 0, 0, 0, 0, 0);
    end else if (t.kind == 5) begin
      expect_o("unm.c0", 1, 0, 32'h0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rnd_bg();
      drive_req(ovl, n);
      expect_o("unm.resp", 0, 1, 32'h0, 1, 0, 0, 0, 0);
    end else begin
      expect_o("ext.c0", 0, 0, 32'h0, 0, 0, 0, 0, 0);
      granted = 1'b0;
      for (int k = 0; k < T; k++) begin
        @(negedge clk);
        rnd_bg();
        ext_gnt = (k == t.gd);
        if (ext_gnt) begin
          expect_o("ext.gnt", 1, 0, 32'h0, 0, 0, 0, 0, 1);
          granted = 1'b1;
          break;
        end else if (k == T - 1) begin
          expect_o("ext.gnt_tmo", 1, 0, 32'h0, 0, 0, 0, 0, 0);
          tmo_m = sat_inc(tmo_m);
        end else begin
          expect_o("ext.gwait", 0, 0, 32'h0, 0, 0, 0, 0, 1);
        end
      end
      if (granted) begin
        granted = 1'b0;
        for (int j = 0; j < T; j++) begin
          @(negedge clk);
          rnd_bg();
          bus.req = 1'b0; bus.addr = 32'h0; bus.we = 1'b0;
          ext_rvalid = (j == t.rd);
          if (ext_rvalid) begin
            drive_req(ovl, n);
            expect_o("ext.resp", 0, 1, ext_rdata, 0, 0, 0, 0, 0);
            granted = 1'b1;
            break;
          end else begin
            expect_o("ext.rwait", 0, 0, 32'h0, 0, 0, 0, 0, 0);
            if (j == T - 1) tmo_m = sat_inc(tmo_m);
          end
        end
      end else begin
        granted = 1'b0;
      end
      if (!granted) begin
        // Error response after a grant or response timeout.
        @(negedge clk);
        rnd_bg();
        drive_req(ovl, n);
        expect_o("ext.err", 0, 1, 32'h0, 1, 0, 0, 0, 0);
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rnd_bg();
      bus.req = 1'b0; bus.addr = 32'h0; bus.we = 1'b0;
      expect_o("idle", 0, 0, 32'h0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t t, n, z;
    bit ovl;
    rst_ni = 1'b0;
    bus.req = 1'b0; bus.addr = 32'h0; bus.we = 1'b0;
    dram_rd = '0; iram_rd = '0; uart_rd = '0;
    ext_gnt = 1'b0; ext_rvalid = 1'b0; ext_rdata = '0;
    z = '{addr: 32'h0, we: 1'b0, kind: 0, gd: 0, rd: 0, data: 32'h0};
    #3;
    expect_o("reset", 0, 0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // DRAM read
    run('{addr: 32'h0000_0010, we: 1'b0, kind: 0, gd: 0, rd: 0, data: 32'hCAFEF00D}, z, 0);
    idle(1);
    // External write: ext_req for 4 cycles, response 2 cycles after grant
    run('{addr: 32'h0E00_0004, we: 1'b1, kind: 3, gd: 3, rd: 1, data: 32'h0}, z, 0);
    idle(1);
    // Unmapped read
    run('{addr: 32'h5500_0000, we: 1'b0, kind: 5, gd: 0, rd: 0, data: 32'h0}, z, 0);
    idle(1);
    // Grant timeout
    run('{addr: 32'h0E00_0000, we: 1'b0, kind: 3, gd: T + 10, rd: 0, data: 32'h0}, z, 0);
    idle(1);
    // Response timeout, then a late bridge response 5 cycles after the error
    run('{addr: 32'h0F00_0008, we: 1'b0, kind: 4, gd: 1, rd: T + 10, data: 32'h0}, z, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rnd_bg();
      ext_gnt = 1'b0;
      ext_rvalid = (i == 4);
      bus.req = 1'b0;
      expect_o("late_rvalid", 0, 0, 32'h0, 0, 0, 0, 0, 0);
    end
    run('{addr: 32'h0000_0100, we: 1'b0, kind: 0, gd: 0, rd: 0, data: 32'h1234_5678}, z, 0);

    // Random traffic with optional back-to-back requests
    t = gen();
    for (int i = 0; i < 300; i++) begin
      n = gen();
      ovl = 1'($urandom_range(0, 1));
      run(t, n, ovl);
      if (!ovl) idle($urandom_range(0, 2));
      t = n;
    end
    // Drain the last generated transaction
    run(t, z, 0);
    idle(1);

    // Drive the timeout counter into saturation
    for (int i = 0; i < 260; i++)
      run('{addr: 32'h0E00_0000, we: 1'b0, kind: 3, gd: T + 3, rd: 0, data: 32'h0}, z, 0);
    idle(1);

    // Reset while waiting in the response phase
    @(negedge clk);
    rnd_bg();
    ext_gnt = 1'b0;
    bus.req = 1'b1; bus.addr = 32'h0F00_0000; bus.we = 1'b0;
    expect_o("rst.c0", 0, 0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rnd_bg();
    ext_gnt = 1'b1;
    expect_o("rst.gnt", 1, 0, 32'h0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rnd_bg();
    ext_rvalid = 1'b0;
    bus.req = 1'b0;
    expect_o("rst.rwait", 0, 0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rnd_bg();
    ext_rvalid = 1'b1;
    bus.req = 1'b1; bus.addr = 32'h0A00_0000;
    rst_ni = 1'b0;
    tmo_m = 0;
    expect_o("rst.assert", 0, 0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rnd_bg();
    expect_o("rst.hold", 0, 0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    bus.req = 1'b0;
    expect_o("rst.release", 0, 0, 32'h0, 0, 0, 0, 0, 0);
    run('{addr: 32'h0A00_0000, we: 1'b0, kind: 2, gd: 0, rd: 0, data: 32'h00C0_FFEE}, z, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
